// File: rtl/out_port_arbiter.sv
// Output-port scheduler: round-robin grant among NUM_REQ input queues, then 4-byte serialization.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module out_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PORT_ID = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][31:0] pkt_in,
  output logic [NUM_REQ-1:0]      grant,
  input  logic                    free_out,
  output logic                    put_out,
  output logic [7:0]              payload_out,
  output logic                    busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       hold_q, hold_d;
  logic [7:0]        payload_q, payload_d;
  logic [IdxW-1:0]   winner, cand;

`ifndef ARB_FIXED_PRIO_EN
  logic [IdxW-1:0]   prio_q, prio_d;
  logic              found;
`endif

  // Winner selection is purely combinational so the grant lands in the same cycle.
  always_comb begin
    winner = '0;
    cand   = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IdxW'(i);
      if (req[cand]) winner = cand;
    end
`else
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(prio_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    hold_d     = hold_q;
    payload_d  = payload_q;
    grant      = '0;
`ifndef ARB_FIXED_PRIO_EN
    prio_d     = prio_q;
`endif
    unique case (state_q)
      StIdle: begin
        // No pop strobe while in reset: the popped packet would be lost.
        if (free_out && (|req) && !reset) begin
          grant[winner] = 1'b1;
          hold_d        = pkt_in[winner][23:0];
          payload_d     = pkt_in[winner][31:24];
          byte_idx_d    = 2'd0;
          state_d       = StSend;
`ifndef ARB_FIXED_PRIO_EN
          prio_d        = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`endif
        end
      end
      StSend: begin
        if (byte_idx_q == 2'd3) begin
          state_d = StIdle;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
        // payload_q is the byte on the link next cycle, so fetch one index ahead.
        unique case (byte_idx_q)
          2'd0:    payload_d = hold_q[23:16];
          2'd1:    payload_d = hold_q[15:8];
          2'd2:    payload_d = hold_q[7:0];
          default: payload_d = payload_q;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_idx_q <= 2'd0;
      hold_q     <= '0;
      payload_q  <= 8'h00;
`ifndef ARB_FIXED_PRIO_EN
      prio_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      hold_q     <= hold_d;
      payload_q  <= payload_d;
`ifndef ARB_FIXED_PRIO_EN
      prio_q     <= prio_d;
`endif
    end
  end

  assign put_out     = (state_q == StSend);
  assign busy        = (state_q == StSend);
  assign payload_out = payload_q;

  a_grant_onehot0 : assert property (@(posedge clock) disable iff (reset) $onehot0(grant))
    else $error("out_port_arbiter port %0d: grant not one-hot", PORT_ID);

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: byte-queue reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_out_port_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N-1:0][31:0] pkt_in = '0;
  logic [N-1:0]      grant;
  logic              free_out = 1'b0;
  logic              put_out;
  logic [7:0]        payload_out;
  logic              busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  out_port_arbiter #(.NUM_REQ(N), .PORT_ID(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .pkt_in      (pkt_in),
    .grant       (grant),
    .free_out    (free_out),
    .put_out     (put_out),
    .payload_out (payload_out),
    .busy        (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of bytes still owed to the link; a grant is only possible when
  // nothing is owed. Each cycle with a non-empty queue emits its head byte.
  logic [7:0] m_q[$];
  logic [7:0] m_pay = 8'h00;
  int         m_prio = 0;

  always @(negedge clock) begin
    logic [N-1:0]  eg;
    logic [IW-1:0] wi;
    int            w;
    int            idx;
    bit            put;
    eg = '0;
    w  = -1;
    if (!reset && m_q.size() == 0 && free_out && req != '0) begin
`ifdef ARB_FIXED_PRIO_EN
      for (int k = N - 1; k >= 0; k--) if (req[IW'(k)]) w = k;
`else
      for (int k = 0; k < N; k++) begin
        idx = (m_prio + k) % N;
        if (w < 0 && req[IW'(idx)]) w = idx;
      end
`endif
      eg[IW'(w)] = 1'b1;
    end
    put = (m_q.size() != 0);
    check("model_grant", 32'(grant), 32'(eg));
    check("model_put_out", 32'(put_out), 32'(put));
    check("model_busy", 32'(busy), 32'(put));
    check("model_payload", 32'(payload_out), 32'(put ? m_q[0] : m_pay));
    if (reset) begin
      m_q.delete();
      m_pay  = 8'h00;
      m_prio = 0;
    end else if (put) begin
      m_pay = m_q.pop_front();
    end else if (w >= 0) begin
      wi = IW'(w);
      m_q.push_back(pkt_in[wi][31:24]);
      m_q.push_back(pkt_in[wi][23:16]);
      m_q.push_back(pkt_in[wi][15:8]);
      m_q.push_back(pkt_in[wi][7:0]);
      m_prio = (w + 1) % N;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0]   exp_bytes[4];
    int           order[5];
    logic [N-1:0] req_n;
    logic [N-1:0] one;
    int           last_t;
    bit           found;

    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h12; exp_bytes[2] = 8'h34; exp_bytes[3] = 8'h56;
`ifdef ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif

    // Reset state
    repeat (2) step();
    @(negedge clock);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_put_out", 32'(put_out), 32'h0);
    check("rst_payload", 32'(payload_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    step();
    reset = 1'b0;

    // Single request from queue 2
    req = 4'b0100; free_out = 1'b1; pkt_in[2] = 32'hA5_123456;
    @(negedge clock);
    check("single_grant", 32'(grant), 32'h4);
    step();
    req = '0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      check("single_put", 32'(put_out), 32'h1);
      check("single_byte", 32'(payload_out), 32'(exp_bytes[b]));
      step();
    end
    @(negedge clock);
    check("single_busy_end", 32'(busy), 32'h0);
    check("single_payload_hold", 32'(payload_out), 32'h56);

    // Round-robin order with all requesting, then wrap-around from 3 with req=1001
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < N; i++) pkt_in[i] = 32'h0100_0000 * (i + 1) + 32'h00ABCD;
    req = 4'b1111;
    last_t = 0;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
        @(negedge clock);
        if (grant != '0) begin
          found = 1'b1;
          one = '0;
          one[IW'(order[g])] = 1'b1;
          check("rr_grant", 32'(grant), 32'(one));
          if (g > 0) check("rr_spacing", 32'(cyc - last_t), 32'd5);
          last_t = cyc;
        end
        step();
        if (found && g == 3) req = 4'b1001;
      end
      if (!found) check("rr_timeout", 32'h0, 32'h1);
    end
    req = '0;
    repeat (4) step();

    // Backpressure
    req = 4'b0001; free_out = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("bp_grant", 32'(grant), 32'h0);
      check("bp_put", 32'(put_out), 32'h0);
      step();
    end
    free_out = 1'b1;
    @(negedge clock);
    check("bp_release_grant", 32'(grant), 32'h1);

    // free_out and req changes during SEND are ignored
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 2) begin
        free_out = 1'b0;
        req = 4'b1001;
      end
      @(negedge clock);
      check("ignore_put", 32'(put_out), 32'h1);
    end
    step();
    free_out = 1'b1;
    @(negedge clock);
`ifdef ARB_FIXED_PRIO_EN
    check("ignore_next_grant", 32'(grant), 32'h1);
`else
    check("ignore_next_grant", 32'(grant), 32'h8);
`endif
    step();
    req = '0;
    repeat (4) step();

    // Reset mid-packet: queue 1 granted, reset during byte 1
    req = 4'b0010; pkt_in[1] = 32'h1E_ABCDEF;
    @(negedge clock);
    check("mid_grant", 32'(grant), 32'h2);
    step(); req = '0;
    step(); reset = 1'b1;
    @(negedge clock);
    check("mid_put_before_rst", 32'(put_out), 32'h1);
    step(); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("mid_put_after_rst", 32'(put_out), 32'h0);
      check("mid_busy_after_rst", 32'(busy), 32'h0);
      step();
    end
    req = 4'b1010;
    @(negedge clock);
    check("mid_prio_cleared", 32'(grant), 32'h2);
    step(); req = '0;
    repeat (4) step();

    // Randomized traffic; pkt_in of a requesting queue stays stable
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 99) == 0);
      free_out = ($urandom_range(0, 3) != 0);
      req_n    = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) if (!req[IW'(i)]) pkt_in[IW'(i)] = $urandom;
      req = req_n;
      step();
    end
    reset = 1'b0; req = '0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
